// File: rtl/piradip_cdc_word_apply.sv
// Destination-domain word commit stage. Takes words from the CDC word
// synchronizer and commits them to a registered output. In mode 0 a word is
// committed as soon as it arrives. In mode 1 it is held in a shadow register
// until the next apply strobe. An uncommitted word that is discarded counts
// as an overrun.
module piradip_cdc_word_apply #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_WIDTH = 8
) (
  input  logic                 dst_clk,
  input  logic                 dst_rst,
  input  logic [WIDTH-1:0]     dst_data,
  input  logic                 dst_update,
  input  logic                 apply_mode,
  input  logic                 apply_strobe,
  input  logic                 clear_overrun,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_applied,
  output logic                 pending,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] apply_cnt,
  output logic [CNT_WIDTH-1:0] overrun_cnt
);

  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [WIDTH-1:0]     shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 applied_q, applied_d;
  logic                 overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0] apply_cnt_q, apply_cnt_d;
  logic [CNT_WIDTH-1:0] overrun_cnt_q, overrun_cnt_d;

  logic commit_en;
  logic ovr_event;

  // Next-state: choose the commit source, then update the shadow and counters.
  always_comb begin
    // Mode 0 commits every cycle; mode 1 commits only on a strobe.
    commit_en     = ~apply_mode | apply_strobe;
    // Any new word arriving while one is pending discards the pending one,
    // in either mode and whether or not it is committed this cycle.
    ovr_event     = dst_update & pending_q;

    out_data_d    = out_data_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    applied_d     = 1'b0;
    overrun_d     = ovr_event;
    apply_cnt_d   = apply_cnt_q;
    overrun_cnt_d = overrun_cnt_q;

    if (commit_en && dst_update) begin
      // Newest word wins; it bypasses the shadow.
      out_data_d  = dst_data;
      applied_d   = 1'b1;
      apply_cnt_d = apply_cnt_q + CNT_WIDTH'(1);
      pending_d   = 1'b0;
    end else if (commit_en && pending_q) begin
      out_data_d  = shadow_q;
      applied_d   = 1'b1;
      apply_cnt_d = apply_cnt_q + CNT_WIDTH'(1);
      pending_d   = 1'b0;
    end else if (dst_update) begin
      shadow_d  = dst_data;
      pending_d = 1'b1;
    end

    // A clear coinciding with an overrun still records that overrun.
    if (clear_overrun) begin
      overrun_cnt_d = ovr_event ? CNT_WIDTH'(1) : '0;
    end else if (ovr_event && (overrun_cnt_q != {CNT_WIDTH{1'b1}})) begin
      overrun_cnt_d = overrun_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      out_data_q    <= RESET_VAL;
      shadow_q      <= RESET_VAL;
      pending_q     <= 1'b0;
      applied_q     <= 1'b0;
      overrun_q     <= 1'b0;
      apply_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      out_data_q    <= out_data_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      applied_q     <= applied_d;
      overrun_q     <= overrun_d;
      apply_cnt_q   <= apply_cnt_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_applied = applied_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;
  assign apply_cnt   = apply_cnt_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_piradip_cdc_word_apply.sv
// Testbench for piradip_cdc_word_apply: directed vector table, randomized
// traffic against a behavioural model, and counter saturation/clear sequence.
module tb_piradip_cdc_word_apply;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0] RV = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          rst, upd, mode, stb, clr;
  logic [W-1:0]  data;
  logic [W-1:0]  out_data;
  logic          out_applied, pending, overrun;
  logic [CW-1:0] apply_cnt, overrun_cnt;

  int n_pass = 0;
  int n_total = 0;

  piradip_cdc_word_apply #(
    .WIDTH    (W),
    .RESET_VAL(RV),
    .CNT_WIDTH(CW)
  ) dut (
    .dst_clk      (clk),
    .dst_rst      (rst),
    .dst_data     (data),
    .dst_update   (upd),
    .apply_mode   (mode),
    .apply_strobe (stb),
    .clear_overrun(clr),
    .out_data     (out_data),
    .out_applied  (out_applied),
    .pending      (pending),
    .overrun      (overrun),
    .apply_cnt    (apply_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: the committed word, an optional pending word, counters.
  logic [W-1:0] m_out, m_shadow;
  bit m_pend, m_app, m_ovr;
  int m_acnt, m_ocnt;

  task automatic model(input bit r, input bit u, input logic [W-1:0] d, input bit md,
                       input bit s, input bit c);
    bit now, discard;
    if (r) begin
      m_out = RV; m_shadow = RV; m_pend = 0; m_app = 0; m_ovr = 0; m_acnt = 0; m_ocnt = 0;
    end else begin
      now     = !md || s;
      discard = u && m_pend;
      m_app   = 0;
      if (now && (u || m_pend)) begin
        m_out  = u ? d : m_shadow;
        m_app  = 1;
        m_acnt = (m_acnt + 1) % (1 << CW);
        m_pend = 0;
      end else if (u) begin
        m_shadow = d;
        m_pend   = 1;
      end
      m_ovr = discard;
      if (c) m_ocnt = discard ? 1 : 0;
      else if (discard) m_ocnt = (m_ocnt < (1 << CW) - 1) ? m_ocnt + 1 : m_ocnt;
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit r, input bit u, input logic [W-1:0] d, input bit md,
                      input bit s, input bit c);
    rst = r; upd = u; data = d; mode = md; stb = s; clr = c;
    @(posedge clk);
    model(r, u, d, md, s, c);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_data"}, out_data, m_out);
    chk({tag, ".out_applied"}, W'(out_applied), W'(m_app));
    chk({tag, ".pending"}, W'(pending), W'(m_pend));
    chk({tag, ".overrun"}, W'(overrun), W'(m_ovr));
    chk({tag, ".apply_cnt"}, W'(apply_cnt), W'(m_acnt));
    chk({tag, ".overrun_cnt"}, W'(overrun_cnt), W'(m_ocnt));
  endtask

  typedef struct {
    bit r, u, md, s, c;
    logic [W-1:0] d;
    logic [W-1:0] e_out;
    bit e_app, e_pend, e_ovr;
    int e_acnt, e_ocnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit u, input logic [W-1:0] d, input bit md,
                     input bit s, input bit c, input logic [W-1:0] eo, input bit ea,
                     input bit ep, input bit ev, input int eac, input int eoc);
    vec_t v;
    v.r = r; v.u = u; v.d = d; v.md = md; v.s = s; v.c = c;
    v.e_out = eo; v.e_app = ea; v.e_pend = ep; v.e_ovr = ev; v.e_acnt = eac; v.e_ocnt = eoc;
    vq.push_back(v);
  endtask

  initial begin
    //  rst upd data          md stb clr | out           app pnd ovr acnt ocnt
    add(1, 0, 32'h0,          0, 0, 0,   RV,           0,  0,  0,  0,   0);
    add(1, 1, 32'h5,          1, 1, 0,   RV,           0,  0,  0,  0,   0);
    add(0, 0, 32'h0,          0, 0, 0,   RV,           0,  0,  0,  0,   0);
    add(0, 1, 32'hA5A5_0001,  0, 0, 0,   32'hA5A5_0001, 1, 0,  0,  1,   0);
    add(0, 0, 32'h0,          0, 0, 0,   32'hA5A5_0001, 0, 0,  0,  1,   0);
    add(0, 1, 32'h11,         1, 0, 0,   32'hA5A5_0001, 0, 1,  0,  1,   0);
    add(0, 0, 32'h0,          1, 0, 0,   32'hA5A5_0001, 0, 1,  0,  1,   0);
    add(0, 0, 32'h0,          1, 1, 0,   32'h11,       1,  0,  0,  2,   0);
    add(0, 0, 32'h0,          1, 1, 0,   32'h11,       0,  0,  0,  2,   0);
    add(0, 1, 32'h1,          1, 0, 0,   32'h11,       0,  1,  0,  2,   0);
    add(0, 1, 32'h2,          1, 0, 0,   32'h11,       0,  1,  1,  2,   1);
    add(0, 1, 32'h3,          1, 0, 0,   32'h11,       0,  1,  1,  2,   2);
    add(0, 0, 32'h0,          1, 1, 0,   32'h3,        1,  0,  0,  3,   2);
    add(0, 1, 32'h7,          1, 0, 0,   32'h3,        0,  1,  0,  3,   2);
    add(0, 1, 32'h8,          1, 1, 0,   32'h8,        1,  0,  1,  4,   3);
    add(0, 1, 32'h9,          1, 0, 0,   32'h8,        0,  1,  0,  4,   3);
    add(0, 0, 32'h0,          0, 0, 0,   32'h9,        1,  0,  0,  5,   3);
    add(0, 1, 32'h10,         0, 0, 0,   32'h10,       1,  0,  0,  6,   3);
    add(0, 1, 32'h20,         0, 0, 0,   32'h20,       1,  0,  0,  7,   3);
    add(0, 1, 32'h30,         1, 0, 0,   32'h20,       0,  1,  0,  7,   3);
    add(0, 1, 32'h40,         0, 0, 0,   32'h40,       1,  0,  1,  8,   4);
    add(0, 0, 32'h0,          0, 1, 1,   32'h40,       0,  0,  0,  8,   0);
    add(0, 1, 32'h55,         1, 0, 0,   32'h40,       0,  1,  0,  8,   0);
    add(1, 1, 32'h66,         1, 1, 0,   RV,           0,  0,  0,  0,   0);
    add(0, 0, 32'h0,          1, 1, 0,   RV,           0,  0,  0,  0,   0);

    rst = 1; upd = 0; data = '0; mode = 0; stb = 0; clr = 0;
    m_out = RV; m_shadow = RV;
    @(negedge clk);

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vq[i].r, vq[i].u, vq[i].d, vq[i].md, vq[i].s, vq[i].c);
      chk({tag, ".out_data"}, out_data, vq[i].e_out);
      chk({tag, ".out_applied"}, W'(out_applied), W'(vq[i].e_app));
      chk({tag, ".pending"}, W'(pending), W'(vq[i].e_pend));
      chk({tag, ".overrun"}, W'(overrun), W'(vq[i].e_ovr));
      chk({tag, ".apply_cnt"}, W'(apply_cnt), W'(vq[i].e_acnt));
      chk({tag, ".overrun_cnt"}, W'(overrun_cnt), W'(vq[i].e_ocnt));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, W'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
      chk_model($sformatf("rnd%0d", i));
    end

    // Saturation: 20 overruns on a 4-bit counter, then clear with/without event.
    step(1, 0, '0, 1, 0, 0);
    step(0, 1, 32'hC0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, W'(32'hC1 + i), 1, 0, 0);
      chk_model($sformatf("sat%0d", i));
    end
    chk("sat.overrun_cnt_15", W'(overrun_cnt), 32'd15);
    step(0, 1, 32'hCC, 1, 0, 1);
    chk("clr_with_event.overrun_cnt", W'(overrun_cnt), 32'd1);
    chk("clr_with_event.overrun", W'(overrun), 32'd1);
    step(0, 0, '0, 1, 0, 1);
    chk("clr_alone.overrun_cnt", W'(overrun_cnt), 32'd0);
    chk_model("clr_alone");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
